// File: rtl/bm_rng_pkg.sv
// Shared Box-Muller RNG types and fixed-point formats (log unit, sqrt unit, multiply stage).
package bm_rng_pkg;

    // e = -2*ln(u0) is unsigned (31,24); f = sqrt(e) is unsigned (17,13).
    localparam int unsigned E_W    = 31;
    localparam int unsigned E_FRAC = 24;
    localparam int unsigned F_W    = 17;
    localparam int unsigned F_FRAC = 13;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } sqrt_state_e;

endpackage

// File: rtl/sqrt_step.sv
// One restoring square-root iteration: shifts in two radicand bits and decides one root bit.
module sqrt_step #(
    parameter int unsigned REM_W  = 19,
    parameter int unsigned ROOT_W = 17
) (
    input  logic [REM_W-1:0]  rem,
    input  logic [ROOT_W-1:0] root,
    input  logic [1:0]        bits,
    output logic [REM_W-1:0]  rem_next,
    output logic [ROOT_W-1:0] root_next
);

    logic [REM_W+1:0] rem_sh;
    logic [REM_W-1:0] trial;
    logic             ge;

    // Compare at full shifted width so no remainder bit is lost before the decision.
    assign rem_sh    = {rem, bits};
    assign trial     = {root, 2'b01};
    assign ge        = rem_sh >= {2'b00, trial};
    assign rem_next  = ge ? (rem_sh[REM_W-1:0] - trial) : rem_sh[REM_W-1:0];
    assign root_next = {root[ROOT_W-2:0], ge};

endmodule

// File: rtl/sqrt_unit.sv
// Iterative square root f = sqrt(e), one root bit per clock, valid/ready on both sides.
// Define SQRT_ROUND_EN to round the result to nearest instead of truncating.
module sqrt_unit
    import bm_rng_pkg::*;
#(
    parameter int unsigned IN_W     = E_W,
    parameter int unsigned IN_FRAC  = E_FRAC,
    parameter int unsigned OUT_FRAC = F_FRAC,
    localparam int unsigned S       = 2 * OUT_FRAC - IN_FRAC,
    localparam int unsigned RW      = ((IN_W + S + 1) / 2) * 2,
    localparam int unsigned OUT_W   = RW / 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             e_valid,
    output logic             e_ready,
    input  logic [IN_W-1:0]  e,
    output logic             f_valid,
    input  logic             f_ready,
    output logic [OUT_W-1:0] f
);

    localparam int unsigned REM_W = OUT_W + 2;
    localparam int unsigned CNT_W = $clog2(OUT_W);

    sqrt_state_e      state_q, state_d;
    logic [RW-1:0]    rad_q, rad_d;
    logic [REM_W-1:0] rem_q, rem_d;
    logic [OUT_W-1:0] root_q, root_d;
    logic [OUT_W-1:0] f_q, f_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [REM_W-1:0] rem_step;
    logic [OUT_W-1:0] root_step;
    logic [OUT_W-1:0] f_load;

    sqrt_step #(
        .REM_W  (REM_W),
        .ROOT_W (OUT_W)
    ) u_step (
        .rem       (rem_q),
        .root      (root_q),
        .bits      (rad_q[RW-1 -: 2]),
        .rem_next  (rem_step),
        .root_next (root_step)
    );

`ifdef SQRT_ROUND_EN
    logic [OUT_W:0] root_inc;

    assign root_inc = {1'b0, root_step} + 1'b1;

    // Remainder above root means e lies past root^2 + root, i.e. closer to root + 1.
    always_comb begin
        f_load = root_step;
        if (rem_step > REM_W'(root_step)) begin
            f_load = root_inc[OUT_W] ? '1 : root_inc[OUT_W-1:0];
        end
    end
`else
    assign f_load = root_step;
`endif

    always_comb begin
        state_d = state_q;
        rad_d   = rad_q;
        rem_d   = rem_q;
        root_d  = root_q;
        f_d     = f_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (e_valid) begin
                    rad_d   = RW'(e) << S;
                    rem_d   = '0;
                    root_d  = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                rad_d  = rad_q << 2;
                rem_d  = rem_step;
                root_d = root_step;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(OUT_W - 1)) begin
                    f_d     = f_load;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (f_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rad_q   <= '0;
            rem_q   <= '0;
            root_q  <= '0;
            f_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rad_q   <= rad_d;
            rem_q   <= rem_d;
            root_q  <= root_d;
            f_q     <= f_d;
            cnt_q   <= cnt_d;
        end
    end

    assign e_ready = (state_q == IDLE);
    assign f_valid = (state_q == DONE);
    assign f       = f_q;

endmodule

// File: tb/tb_sqrt_unit.sv
// Scoreboard bench for sqrt_unit; honours SQRT_ROUND_EN for the expected rounding mode.
module tb_sqrt_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        e_valid;
    logic        e_ready;
    logic [30:0] e;
    logic        f_valid;
    logic        f_ready;
    logic [16:0] f;

    int          checks = 0;
    int          errors = 0;
    logic [16:0] exp_q[$];

    sqrt_unit dut (
        .clk     (clk),
        .reset   (reset),
        .e_valid (e_valid),
        .e_ready (e_ready),
        .e       (e),
        .f_valid (f_valid),
        .f_ready (f_ready),
        .f       (f)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Golden model: largest r with r*r <= 4e, found by square comparison.
    function automatic logic [16:0] model(input logic [30:0] ev);
        longint unsigned v, r, t;
        v = 64'(ev) << 2;
        r = 0;
        for (int b = 16; b >= 0; b--) begin
            t = r | (64'd1 << b);
            if (t * t <= v) r = t;
        end
`ifdef SQRT_ROUND_EN
        if (v - r * r > r) r = r + 1;
        if (r > 64'h1FFFF) r = 64'h1FFFF;
`endif
        return r[16:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at negedge with inputs set: account for handshakes at the coming posedge.
    task automatic step();
        if (reset) begin
            @(posedge clk);
            exp_q.delete();
        end else begin
            if (e_valid && e_ready) exp_q.push_back(model(e));
            if (f_valid && f_ready) begin
                if (exp_q.size() == 0) check("spurious_result", 1, 0);
                else check("result", f, exp_q.pop_front());
            end
            @(posedge clk);
        end
        @(negedge clk);
    endtask

    task automatic run_one(input logic [30:0] ev, input logic [16:0] exp_const, input string tag);
        int n;
        e       = ev;
        e_valid = 1'b1;
        step();
        e_valid = 1'b0;
        n = 0;
        while (!f_valid && n < 40) begin
            step();
            n++;
        end
        check({tag, "_latency"}, n, 17);
        check({tag, "_f"}, f, exp_const);
        f_ready = 1'b1;
        step();
        f_ready = 1'b0;
    endtask

    initial begin
        logic [16:0] hold;
        int          n;
        reset   = 1'b1;
        e_valid = 1'b0;
        f_ready = 1'b0;
        e       = '0;
        @(negedge clk);
        step();
        step();
        reset = 1'b0;
        check("rst_e_ready", e_ready, 1);
        check("rst_f_valid", f_valid, 0);
        check("rst_f", f, 0);

        run_one(31'h1000000, 17'h02000, "one");
        run_one(31'h4000000, 17'h04000, "four");
        run_one(31'h0000000, 17'h00000, "zero");
`ifdef SQRT_ROUND_EN
        run_one(31'h3000000, 17'h0376D, "three");
`else
        run_one(31'h3000000, 17'h0376C, "three");
`endif
        run_one(31'h2000000, 17'h02D41, "two");
`ifdef SQRT_ROUND_EN
        run_one(31'h7FFFFFFF, 17'h16A0A, "max");
`else
        run_one(31'h7FFFFFFF, 17'h16A09, "max");
`endif

        // Backpressure: result must hold and new samples must be refused.
        e       = 31'h2000000;
        e_valid = 1'b1;
        step();
        e_valid = 1'b0;
        n = 0;
        while (!f_valid && n < 40) begin
            step();
            n++;
        end
        check("bp_latency", n, 17);
        hold    = f;
        e       = 31'h1234567;
        e_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_f_stable", f, hold);
            check("bp_f_valid", f_valid, 1);
            check("bp_e_ready", e_ready, 0);
        end
        e_valid = 1'b0;
        f_ready = 1'b1;
        step();
        f_ready = 1'b0;
        check("bp_release_ready", e_ready, 1);
        check("bp_release_valid", f_valid, 0);
        for (int i = 0; i < 20; i++) step();
        check("bp_no_capture", f_valid, 0);

        // Reset during the eighth iteration edge.
        e       = 31'h4000000;
        e_valid = 1'b1;
        step();
        e_valid = 1'b0;
        for (int i = 0; i < 7; i++) step();
        check("pre_rst_busy", e_ready, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_e_ready", e_ready, 1);
        check("mid_rst_f_valid", f_valid, 0);
        check("mid_rst_f", f, 0);
        run_one(31'h1000000, 17'h02000, "post_rst");

        // Random stream with random handshakes.
        for (int i = 0; i < 600; i++) begin
            e_valid = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0:       e = '0;
                1:       e = '1;
                default: e = 31'($urandom);
            endcase
            f_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        e_valid = 1'b0;
        f_ready = 1'b1;
        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            step();
            n++;
        end
        check("drain_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sqrt_unit.md
Name: sqrt_unit

Overview:
- Box-Muller stage directly downstream of the log unit.
- Consumes e = -2·ln(u0), unsigned fixed point (31,24), and produces f = sqrt(e) for the sin/cos multiply stage.
- Iterative digit-by-digit (restoring) integer square root, one result bit per clock, with valid/ready handshakes on both sides.
- Output format is (17,13): 4 integer bits, 13 fractional bits.

Parameters:
- IN_W, 31, input width.
- IN_FRAC, 24, input fractional bits.
- OUT_FRAC, 13, output fractional bits; must satisfy 2·OUT_FRAC ≥ IN_FRAC.
- Derived, not overridable:
  - S = 2·OUT_FRAC − IN_FRAC = 2.
  - RW = IN_W + S rounded up to even = 34.
  - OUT_W = RW/2 = 17.

Ports:
- clk  in  1  clock (all logic on posedge)
- reset  in  1  synchronous, active-high reset
- e_valid  in  1  e holds a new sample
- e_ready  out  1  unit can accept a sample
- e  in  IN_W  input, unsigned (31,24)
- f_valid  out  1  f holds a result
- f_ready  in  1  downstream accepts f
- f  out  OUT_W  sqrt(e), unsigned (17,13)

Behaviour:
- Reset: evaluated only at posedge clk; overrides everything, including mid-calculation.
  - State IDLE, e_ready=1, f_valid=0, f=0.
  - Iteration counter, radicand, remainder and root registers all 0.
- State machine, IDLE → CALC → DONE:
  - IDLE: e_ready=1. On e_valid at a posedge, load radicand R = {pad, e, S zeros} (RW bits), remainder=0, root=0, count=0; go to CALC.
  - CALC: e_ready=0. One restoring step per edge:
    - rem' = (rem<<2) | top two bits of R; R <<= 2.
    - trial = (root<<2)|1.
    - If rem' ≥ trial: rem = rem' − trial, root = (root<<1)|1. Else: rem = rem', root = root<<1.
    - After the OUT_W-th step (count = OUT_W−1), go to DONE and register f.
  - DONE: f_valid=1, e_ready=0. On f_ready at a posedge, go to IDLE with f_valid=0.
  - f holds its last value until the next DONE load.
- Timing:
  - Accept edge t; iteration edges t+1 … t+17; f_valid high from edge t+17.
  - Latency 17 cycles; throughput one result per 19 cycles with f_ready held high.
- e_valid while not in IDLE is ignored; no sample is captured.
- f_ready while f_valid=0 is ignored.
- Widths:
  - Remainder register is OUT_W+2 bits; the compare uses full width, with no truncation.
  - root = floor(sqrt(R)), i.e. f truncated toward zero.
- Boundaries:
  - e=0 gives f=0.
  - e = all-ones gives f = 0x16A09.
  - The max result is below 2^OUT_W, so no saturation is needed in truncating mode.

Optional Feature:
- Macro: SQRT_ROUND_EN.
- Defined: on the DONE load, f = root + 1 if the final remainder > root, otherwise root. This is round-to-nearest; exact ties cannot occur. Saturate at all-ones if the increment would overflow OUT_W. Adds no latency.
- Undefined: f = root (floor). The rounding adder is not built.

Decomposition:
- Shared package bm_rng_pkg:
  - E_W=31, E_FRAC=24, F_W=17, F_FRAC=13.
  - State enum typedef {IDLE, CALC, DONE}.
  - Fixed-point format constants, also shared with log_unit and the multiply stage.
- One sub-module, sqrt_step: combinational single restoring iteration.
  - Inputs: rem, root, two radicand bits.
  - Outputs: next rem, next root.
- sqrt_unit holds the FSM, counter and registers.

Test Plan:
- e=0x1000000 (1.0) → f=0x2000 (1.0) with f_valid exactly 17 cycles after the accept edge; e=0x4000000 (4.0) → f=0x4000; e=0 → f=0.
- e=0x3000000 (3.0) → f=0x376C truncating, 0x376D with SQRT_ROUND_EN; e=0x2000000 → f=0x2D41 in both builds.
- e=0x7FFFFFFF → f=0x16A09 truncating, 0x16A0A with SQRT_ROUND_EN (remainder 166827 > root).
- Backpressure: hold f_ready=0 for 10 cycles after f_valid → f and f_valid stable, e_ready=0, a new e_valid is not captured; release → IDLE next edge.
- Reset asserted on the 8th CALC cycle → next edge IDLE, e_ready=1, f_valid=0, f=0; a fresh e=0x1000000 still yields 0x2000.
- Random e stream with random e_valid/f_ready against a floor(sqrt(e·4)) golden model → every accepted sample produces exactly one matching f, in order.
